// File: rtl/mem_access.sv
// Memory stage of the 5-stage pipeline: runs req/ack data-bus transactions for loads and
// stores, aligns and extends load data, and forwards the write-back triple to mem_wb.
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_waddr,
  input  logic        ex_we,
  input  logic [3:0]  ex_memop,
  input  logic [31:0] ex_maddr,
  input  logic [31:0] ex_sdata,
  output logic [31:0] mem_wdata,
  output logic [4:0]  mem_waddr,
  output logic        mem_we,
  output logic        stall_req,
  output logic        misalign_exc,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic       LP_TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0] LP_LAST  = (TIMEOUT_CYCLES == 0) ? 8'd0 : 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_count;
  logic [31:0] r_result;
  logic [3:0]  r_op;
  logic [1:0]  r_lane;
  logic        r_isLoad;
  logic        r_aborted;

  logic        w_isLoad;
  logic        w_isStore;
  logic        w_isMem;
  logic        w_isHalf;
  logic        w_isWord;
  logic        w_misaligned;
  logic        w_timeout;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata;

  function automatic logic [31:0] extendLoad(input logic [3:0]  op,
                                             input logic [1:0]  lane,
                                             input logic [31:0] data);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = data[7:0];
      2'd1:    b = data[15:8];
      2'd2:    b = data[23:16];
      default: b = data[31:24];
    endcase
    h = lane[1] ? data[31:16] : data[15:0];
    case (op)
      4'd1:    res = {{24{b[7]}}, b};
      4'd2:    res = {24'd0, b};
      4'd3:    res = {{16{h[15]}}, h};
      4'd4:    res = {16'd0, h};
      default: res = data;
    endcase
    return res;
  endfunction

  // Opcode decode plus lane enables and replicated store data for the bus.
  always_comb begin
    w_isLoad     = (ex_memop >= 4'd1) && (ex_memop <= 4'd5);
    w_isStore    = (ex_memop >= 4'd6) && (ex_memop <= 4'd8);
    w_isMem      = w_isLoad || w_isStore;
    w_isHalf     = (ex_memop == 4'd3) || (ex_memop == 4'd4) || (ex_memop == 4'd7);
    w_isWord     = (ex_memop == 4'd5) || (ex_memop == 4'd8);
    w_misaligned = (w_isHalf && ex_maddr[0]) || (w_isWord && (ex_maddr[1:0] != 2'd0));
    w_timeout    = LP_TO_EN && (r_count == LP_LAST);
    if (w_isWord) begin
      w_sel   = 4'b1111;
      w_wdata = ex_sdata;
    end else if (w_isHalf) begin
      w_sel   = ex_maddr[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{ex_sdata[15:0]}};
    end else begin
      w_sel   = 4'b0001 << ex_maddr[1:0];
      w_wdata = {4{ex_sdata[7:0]}};
    end
  end

  always_comb begin
    mem_wdata    = ex_wdata;
    mem_waddr    = ex_waddr;
    mem_we       = ex_we;
    stall_req    = 1'b0;
    misalign_exc = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_isMem) begin
          mem_we = 1'b0;
          if (w_misaligned) misalign_exc = 1'b1;
          else              stall_req    = 1'b1;
        end
      end
      BUSY: begin
        mem_we    = 1'b0;
        stall_req = 1'b1;
      end
      DONE: begin
        mem_wdata = r_result;
        mem_we    = (r_isLoad && !r_aborted) ? ex_we : 1'b0;
      end
      default: mem_we = 1'b0;
    endcase
  end

  // Ack beats a timeout landing on the same cycle; DONE lasts exactly one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_count   <= 8'd0;
      r_result  <= 32'd0;
      r_op      <= 4'd0;
      r_lane    <= 2'd0;
      r_isLoad  <= 1'b0;
      r_aborted <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_sel   <= 4'd0;
      bus_wdata <= 32'd0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_isMem && !w_misaligned) begin
            bus_req   <= 1'b1;
            bus_we    <= w_isStore;
            bus_addr  <= {ex_maddr[31:2], 2'b00};
            bus_sel   <= w_sel;
            bus_wdata <= w_wdata;
            r_count   <= 8'd0;
            r_op      <= ex_memop;
            r_lane    <= ex_maddr[1:0];
            r_isLoad  <= w_isLoad;
            r_aborted <= 1'b0;
            r_state   <= BUSY;
          end
        end
        BUSY: begin
          r_count <= r_count + 8'd1;
          if (bus_ack) begin
            if (r_isLoad) r_result <= extendLoad(r_op, r_lane, bus_rdata);
            bus_req <= 1'b0;
            r_state <= DONE;
          end else if (w_timeout) begin
            bus_req   <= 1'b0;
            bus_err   <= 1'b1;
            r_aborted <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases pinned to literals plus randomized
// transactions checked every cycle against a transaction-level model.
module tb_mem_access;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_waddr;
  logic        ex_we;
  logic [3:0]  ex_memop;
  logic [31:0] ex_maddr;
  logic [31:0] ex_sdata;
  logic [31:0] mem_wdata;
  logic [4:0]  mem_waddr;
  logic        mem_we;
  logic        stall_req;
  logic        misalign_exc;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  mem_access #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .ex_wdata(ex_wdata), .ex_waddr(ex_waddr), .ex_we(ex_we), .ex_memop(ex_memop),
    .ex_maddr(ex_maddr), .ex_sdata(ex_sdata),
    .mem_wdata(mem_wdata), .mem_waddr(mem_waddr), .mem_we(mem_we),
    .stall_req(stall_req), .misalign_exc(misalign_exc), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int nCompared   = 0;
  int nMismatched = 0;

  bit          enWdata, enWaddr, enWe, enStall, enMis, enReq, enErr, enBus, enBusWd, enPinRes, enPinSel, enPinWd;
  logic [31:0] eWdata, eBusAddr, eBusWdata, ePinRes, ePinWd;
  logic [4:0]  eWaddr;
  logic [3:0]  eBusSel, ePinSel;
  logic        eWe, eStall, eMis, eReq, eErr, eBusWe;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Single compare process: every enabled expectation is checked mid-cycle.
  always @(negedge clk) begin
    if (enWdata)  checkOutput("mem_wdata", mem_wdata, eWdata);
    if (enWaddr)  checkOutput("mem_waddr", 32'(mem_waddr), 32'(eWaddr));
    if (enWe)     checkOutput("mem_we", 32'(mem_we), 32'(eWe));
    if (enStall)  checkOutput("stall_req", 32'(stall_req), 32'(eStall));
    if (enMis)    checkOutput("misalign_exc", 32'(misalign_exc), 32'(eMis));
    if (enReq)    checkOutput("bus_req", 32'(bus_req), 32'(eReq));
    if (enErr)    checkOutput("bus_err", 32'(bus_err), 32'(eErr));
    if (enBus) begin
      checkOutput("bus_we", 32'(bus_we), 32'(eBusWe));
      checkOutput("bus_addr", bus_addr, eBusAddr);
      checkOutput("bus_sel", 32'(bus_sel), 32'(eBusSel));
    end
    if (enBusWd)  checkOutput("bus_wdata", bus_wdata, eBusWdata);
    if (enPinRes) checkOutput("pinned_result", mem_wdata, ePinRes);
    if (enPinSel) checkOutput("pinned_sel", 32'(bus_sel), 32'(ePinSel));
    if (enPinWd)  checkOutput("pinned_wdata", bus_wdata, ePinWd);
  end

  task automatic clearExp();
    {enWdata, enWaddr, enWe, enStall, enMis, enReq, enErr, enBus, enBusWd} = '0;
    {enPinRes, enPinSel, enPinWd} = '0;
  endtask

  // Transaction-level model: access size in bytes, 0 for anything that is not a memory op.
  function automatic int opSize(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: return 1;
      4'd3, 4'd4, 4'd7: return 2;
      4'd5, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic logic [31:0] loadResult(input logic [3:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    int          bits;
    logic [31:0] v;
    bits = 8 * opSize(op);
    if (bits == 32) return rdata;
    v = (rdata >> (8 * int'(addr[1:0]))) & ((32'd1 << bits) - 32'd1);
    if ((op == 4'd1 || op == 4'd3) && v[bits-1]) v = v - (32'd1 << bits);
    return v;
  endfunction

  function automatic logic [31:0] replicate(input int size, input logic [31:0] sdata);
    if (size == 1) return {24'd0, sdata[7:0]} * 32'h0101_0101;
    if (size == 2) return {16'd0, sdata[15:0]} * 32'h0001_0001;
    return sdata;
  endfunction

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [31:0] wdata, input logic [4:0] waddr, input logic we,
                               input int ackAt, input logic [31:0] rdata,
                               input bit pinRes, input logic [31:0] pinResV,
                               input bit pinSel, input logic [3:0] pinSelV,
                               input bit pinWd, input logic [31:0] pinWdV);
    int  sz, busyN;
    bit  isMem, isLd, aligned, ackHit;
    sz      = opSize(op);
    isMem   = (sz != 0);
    isLd    = (op >= 4'd1) && (op <= 4'd5);
    aligned = isMem && ((int'(addr[1:0]) % sz) == 0);
    ackHit  = (ackAt >= 1) && (ackAt <= T);
    busyN   = ackHit ? ackAt : T;

    ex_memop = op; ex_maddr = addr; ex_sdata = sdata;
    ex_wdata = wdata; ex_waddr = waddr; ex_we = we;
    bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
    clearExp();
    enReq = 1; eReq = 0; enErr = 1; eErr = 0; enStall = 1; enMis = 1; enWe = 1;
    if (!isMem) begin
      eStall = 0; eMis = 0; eWe = we;
      enWdata = 1; eWdata = wdata; enWaddr = 1; eWaddr = waddr;
    end else if (!aligned) begin
      eStall = 0; eMis = 1; eWe = 0;
    end else begin
      eStall = 1; eMis = 0; eWe = 0;
    end
    @(posedge clk); #1;
    if (!aligned) return;

    for (int i = 1; i <= busyN; i++) begin
      bus_ack   = ackHit && (i == ackAt);
      bus_rdata = bus_ack ? rdata : $urandom;
      clearExp();
      enStall = 1; eStall = 1; enMis = 1; eMis = 0; enWe = 1; eWe = 0;
      enReq = 1; eReq = 1; enErr = 1; eErr = 0;
      enBus = 1; eBusWe = !isLd; eBusAddr = addr & ~32'd3;
      eBusSel = 4'(((1 << sz) - 1) << int'(addr[1:0]));
      enBusWd = !isLd; eBusWdata = replicate(sz, sdata);
      enPinSel = pinSel; ePinSel = pinSelV;
      enPinWd = pinWd; ePinWd = pinWdV;
      @(posedge clk); #1;
    end

    bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
    clearExp();
    enStall = 1; eStall = 0; enMis = 1; eMis = 0; enReq = 1; eReq = 0;
    enErr = 1; eErr = !ackHit; enWaddr = 1; eWaddr = waddr;
    enWe = 1; eWe = (isLd && ackHit) ? we : 1'b0;
    if (isLd && ackHit) begin
      enWdata = 1; eWdata = loadResult(op, addr, rdata);
      enPinRes = pinRes; ePinRes = pinResV;
    end
    @(posedge clk); #1;
    bus_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    ex_memop = 4'd0; ex_maddr = 32'd0; ex_sdata = 32'd0;
    ex_wdata = 32'h0000_CAFE; ex_waddr = 5'd3; ex_we = 1'b1;
    bus_ack = 1'b0; bus_rdata = 32'd0;
    clearExp();
    enReq = 1; eReq = 0; enErr = 1; eErr = 0; enStall = 1; eStall = 0; enMis = 1; eMis = 0;
    enBus = 1; eBusWe = 0; eBusAddr = 32'd0; eBusSel = 4'd0; enBusWd = 1; eBusWdata = 32'd0;
    enWdata = 1; eWdata = 32'h0000_CAFE; enWaddr = 1; eWaddr = 5'd3; enWe = 1; eWe = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    applyStimulus(4'd0, 32'h0, 32'h0, 32'h1234_5678, 5'd5, 1'b1, 0, 32'h0, 0, 32'h0, 0, 4'h0, 0, 32'h0);
    applyStimulus(4'd5, 32'h100, 32'h0, 32'h0, 5'd7, 1'b1, 3, 32'hDEAD_BEEF,
                  1, 32'hDEAD_BEEF, 1, 4'b1111, 0, 32'h0);
    applyStimulus(4'd1, 32'h203, 32'h0, 32'h0, 5'd8, 1'b1, 1, 32'h8011_2233,
                  1, 32'hFFFF_FF80, 1, 4'b1000, 0, 32'h0);
    applyStimulus(4'd2, 32'h203, 32'h0, 32'h0, 5'd8, 1'b1, 1, 32'h8011_2233,
                  1, 32'h0000_0080, 1, 4'b1000, 0, 32'h0);
    applyStimulus(4'd7, 32'h302, 32'h0000_ABCD, 32'h0, 5'd9, 1'b1, 2, 32'h0,
                  0, 32'h0, 1, 4'b1100, 1, 32'hABCD_ABCD);
    applyStimulus(4'd5, 32'h102, 32'h0, 32'h0, 5'd1, 1'b1, 1, 32'h0, 0, 32'h0, 0, 4'h0, 0, 32'h0);
    applyStimulus(4'd3, 32'h101, 32'h0, 32'h0, 5'd1, 1'b1, 1, 32'h0, 0, 32'h0, 0, 4'h0, 0, 32'h0);
    applyStimulus(4'd5, 32'h104, 32'h0, 32'h0, 5'd2, 1'b1, 0, 32'h0, 0, 32'h0, 0, 4'h0, 0, 32'h0);
    applyStimulus(4'd3, 32'h10, 32'h0, 32'h0, 5'd4, 1'b1, T, 32'h1234_8001,
                  1, 32'hFFFF_8001, 1, 4'b0011, 0, 32'h0);
    applyStimulus(4'd12, 32'h0, 32'h0, 32'h5555_AAAA, 5'd31, 1'b1, 1, 32'h0, 0, 32'h0, 0, 4'h0, 0, 32'h0);

    for (int n = 0; n < 200; n++) begin
      applyStimulus(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom,
                    5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 6), $urandom, 0, 32'h0, 0, 4'h0, 0, 32'h0);
    end

    // Reset lands in the middle of a load; the abandoned request must vanish at once.
    ex_memop = 4'd5; ex_maddr = 32'h40; ex_we = 1'b1; bus_ack = 1'b0;
    clearExp(); enReq = 1; eReq = 0; enStall = 1; eStall = 1;
    @(posedge clk); #1;
    clearExp(); enReq = 1; eReq = 1;
    @(posedge clk); #2;
    rst = 1'b0;
    clearExp(); enReq = 1; eReq = 0; enErr = 1; eErr = 0;
    enBus = 1; eBusWe = 0; eBusAddr = 32'd0; eBusSel = 4'd0;
    @(posedge clk); #1;
    rst = 1'b1;
    ex_memop = 4'd0; ex_wdata = 32'h0BAD_F00D; ex_waddr = 5'd12; ex_we = 1'b1;
    bus_ack = 1'b1; bus_rdata = $urandom;
    clearExp(); enReq = 1; eReq = 0; enErr = 1; eErr = 0; enStall = 1; eStall = 0;
    enWdata = 1; eWdata = 32'h0BAD_F00D; enWaddr = 1; eWaddr = 5'd12; enWe = 1; eWe = 1;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(posedge clk); #1;
    applyStimulus(4'd4, 32'h22, 32'h0, 32'h0, 5'd6, 1'b1, 2, 32'hF00D_1234,
                  1, 32'h0000_F00D, 1, 4'b1100, 0, 32'h0);

    clearExp();
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage of the 5-stage pipeline. Sits between the ex_mem pipeline register and the mem_wb register.
- Non-memory instructions pass the write-back triple (data, register address, write enable) straight through.
- Loads and stores run a multi-cycle req/ack transaction on the data bus. Pipeline stall is requested until the access completes.
- Load data is byte/half-aligned and sign- or zero-extended before it is forwarded to mem_wb.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles spent in BUSY waiting for bus_ack before abort. Range 1..255; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low (RstEnable = 0)
- ex_wdata  in  32  ALU result for non-memory ops
- ex_waddr  in  5  destination register
- ex_we  in  1  register write enable
- ex_memop  in  4  0=NONE 1=LB 2=LBU 3=LH 4=LHU 5=LW 6=SB 7=SH 8=SW; 9-15 treated as NONE
- ex_maddr  in  32  effective address
- ex_sdata  in  32  store data (low bits significant)
- mem_wdata  out  32  write-back data to mem_wb
- mem_waddr  out  5  write-back register to mem_wb
- mem_we  out  1  write-back enable to mem_wb
- stall_req  out  1  hold upstream stages (combinational)
- misalign_exc  out  1  misaligned access flag (combinational)
- bus_err  out  1  one-cycle pulse on timeout abort
- bus_req  out  1  transaction valid (registered)
- bus_we  out  1  1=write (registered)
- bus_addr  out  32  word address, bits[1:0] forced 0 (registered)
- bus_sel  out  4  byte lane enables, bit k = bits[8k+7:8k] (registered)
- bus_wdata  out  32  store data, replicated to lanes (registered)
- bus_ack  in  1  completion; bus_rdata valid same cycle
- bus_rdata  in  32  read data

Behaviour:
- Little-endian; lane = ex_maddr[1:0].
- Alignment rules: halfword ops require addr[0]=0; word ops require addr[1:0]=0.
- Reset (async, rst=0):
  - State goes to IDLE; counter = 0; latched result = 0.
  - bus_req, bus_we, bus_sel, bus_addr, bus_wdata, bus_err all 0.
  - Combinational outputs take their IDLE/NONE values.
- State machine: IDLE, BUSY, DONE.
- IDLE, ex_memop NONE:
  - mem_wdata=ex_wdata, mem_waddr=ex_waddr, mem_we=ex_we.
  - stall_req=0.
- IDLE, misaligned memory op:
  - misalign_exc=1, mem_we=0, stall_req=0.
  - No bus access; stay in IDLE.
- IDLE, aligned memory op:
  - stall_req=1, mem_we=0.
  - At the next edge: bus_req=1, bus_addr, bus_sel, bus_we and bus_wdata are loaded; counter cleared; go to BUSY.
  - Byte ops: sel = 1<<lane, wdata = {4{sdata[7:0]}}.
  - Half ops: sel = 0011 or 1100, wdata = {2{sdata[15:0]}}.
  - Word ops: sel = 1111, wdata = sdata.
- BUSY:
  - stall_req=1, mem_we=0; bus signals held stable.
  - Counter increments each cycle.
  - On bus_ack: capture extended load data (stores capture nothing), drop bus_req, go to DONE.
  - On timeout (counter reaches TIMEOUT_CYCLES-1 without ack): drop bus_req, pulse bus_err, go to DONE marked aborted.
  - Ack and timeout in the same cycle: ack wins.
- DONE (exactly one cycle):
  - stall_req=0; mem_waddr=ex_waddr.
  - Load: mem_wdata = latched result, mem_we = ex_we.
  - Store or aborted access: mem_we=0.
  - Next edge returns to IDLE; ex_mem has advanced, so no re-issue occurs.
- Load extension:
  - LB/LH: sign-extend the selected byte/half.
  - LBU/LHU: zero-extend.
  - LW: full word.
- bus_ack outside BUSY is ignored.
- Reset asserted in BUSY: bus_req drops immediately, the transaction is abandoned, and a late ack is ignored.
- The bus slave must tolerate an abandoned request.
- Latency: a memory op with ack on the k-th BUSY cycle stalls for k+1 cycles; write-back data is valid in the DONE cycle.

Test Plan:
- ALU op, ex_wdata=0x12345678, waddr=5, we=1 -> same values on mem_* in the same cycle; stall_req=0; bus_req never rises.
- LW addr 0x100, ack on 3rd BUSY cycle with rdata 0xDEADBEEF -> bus_addr=0x100, sel=1111, stall high for 4 cycles, DONE shows mem_wdata=0xDEADBEEF, mem_we=1.
- LB addr 0x203, rdata 0x80112233 -> sel=1000, result 0xFFFFFF80; LBU same stimulus -> 0x00000080.
- SH addr 0x302, sdata 0x0000ABCD -> bus_we=1, sel=1100, wdata=0xABCDABCD; DONE mem_we=0.
- LW addr 0x102 -> misalign_exc=1, mem_we=0, no bus_req; LH addr 0x101 -> same result.
- LW with no ack, TIMEOUT_CYCLES=4 -> bus_err pulses after 4 BUSY cycles, mem_we=0.
- Separate run: rst=0 mid-BUSY -> bus_req=0 immediately; an ack after rst release has no effect.
